// File: rtl/neander_x_pkg.sv
// neander_x_pkg: opcode, ALU-op and FSM-state encodings shared by the Neander-X core.
package neander_x_pkg;
  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_STA = 4'h1, OP_LDA = 4'h2, OP_ADD = 4'h3,
    OP_OR  = 4'h4, OP_AND = 4'h5, OP_NOT = 4'h6, OP_SUB = 4'h7,
    OP_XOR = 4'h8, OP_SHL = 4'h9, OP_SHR = 4'hA, OP_NEG = 4'hB,
    OP_HLT = 4'hF
  } op_t;
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_NOT = 4'b0101,
    ALU_SHL = 4'b0110, ALU_SHR = 4'b0111, ALU_NEG = 4'b1000
  } alu_op_t;
  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_EXEC, S_WR, S_HALT
  } state_t;
  function automatic alu_op_t alu_op_of(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_NOT:  return ALU_NOT;
      OP_SHL:  return ALU_SHL;
      OP_SHR:  return ALU_SHR;
      OP_NEG:  return ALU_NEG;
      default: return ALU_ADD;
    endcase
  endfunction
  function automatic logic is_mem_op(input logic [3:0] op);
    return op inside {OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
  endfunction
  function automatic logic is_unary(input logic [3:0] op);
    return op inside {OP_NOT, OP_SHL, OP_SHR, OP_NEG};
  endfunction
  function automatic logic sets_carry(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_NEG};
  endfunction
  function automatic logic is_reserved(input logic [3:0] op);
    return op inside {[4'hC:4'hE]};
  endfunction
endpackage

// File: rtl/neander_x_exec_ctrl.sv
// neander_x_exec_ctrl: execute-stage FSM sequencing operand reads, ALU ops, stores and halt.
module neander_x_exec_ctrl
  import neander_x_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [3:0] instr_op,
  input  logic [7:0] instr_addr,
  output logic       mem_rd_req,
  output logic [7:0] mem_addr,
  input  logic       mem_rd_valid,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  output logic [7:0] ac,
  output logic       flag_n,
  output logic       flag_z,
  output logic       flag_c,
  output logic       done,
  output logic       illegal,
  output logic       halted
);
  state_t     r_state;
  logic [3:0] r_op;
  logic [7:0] r_addr, r_opnd, r_ac;
  logic       r_n, r_z, r_c, r_done, r_ill, r_halt;
  logic [7:0] w_ac_next;
  logic       w_local;
  assign w_ac_next   = (r_op == OP_LDA) ? r_opnd : alu_result;
  assign w_local     = !is_mem_op(instr_op) && !is_unary(instr_op) && instr_op != OP_STA && instr_op != OP_HLT;
  assign instr_ready = r_state == S_IDLE;
  assign mem_rd_req  = r_state == S_RD_REQ;
  assign mem_wr_en   = r_state == S_WR;
  assign mem_addr    = r_addr;
  assign mem_wr_data = r_ac;
  assign alu_a       = r_ac;
  assign alu_b       = r_opnd;
  assign alu_op      = (r_state == S_EXEC) ? alu_op_of(r_op) : ALU_ADD;
  assign ac          = r_ac;
  assign flag_n      = r_n;
  assign flag_z      = r_z;
  assign flag_c      = r_c;
  assign done        = r_done;
  assign illegal     = r_ill;
  assign halted      = r_halt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= OP_NOP;
      r_addr  <= '0;
      r_opnd  <= '0;
      r_ac    <= '0;
      r_n     <= 1'b0;
      r_z     <= 1'b1;
      r_c     <= 1'b0;
      r_done  <= 1'b0;
      r_ill   <= 1'b0;
      r_halt  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ill  <= 1'b0;
      case (r_state)
        S_IDLE: if (instr_valid) begin
          r_op    <= instr_op;
          r_addr  <= instr_addr;
          r_state <= is_mem_op(instr_op) ? S_RD_REQ :
                     is_unary(instr_op)  ? S_EXEC   :
                     instr_op == OP_STA  ? S_WR     :
                     instr_op == OP_HLT  ? S_HALT   : S_IDLE;
          r_done  <= w_local;
          r_ill   <= w_local && is_reserved(instr_op);
          r_halt  <= instr_op == OP_HLT;
        end
        S_RD_REQ, S_RD_WAIT: begin
          if (mem_rd_valid) r_opnd <= mem_rd_data;
          r_state <= mem_rd_valid ? S_EXEC : S_RD_WAIT;
        end
        S_EXEC: begin
          r_ac    <= w_ac_next;
          r_n     <= w_ac_next[7];
          r_z     <= w_ac_next == 8'h00;
          if (sets_carry(r_op)) r_c <= alu_carry;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        S_WR: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/neander_x_exec_ctrl.md
NEANDER_X_EXEC_CTRL -- requirements
Module: neander_x_exec_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed in REQ-002 to REQ-009.
REQ-002 clk  in  1  sole clock, rising edge; reset  in  1  synchronous active-high reset.
REQ-003 instr_valid  in  1  decoded instruction present; instr_ready  out  1  controller can accept.
REQ-004 instr_op  in  4  execute opcode; instr_addr  in  8  operand/store address.
REQ-005 mem_rd_req  out  1  read strobe; mem_addr  out  8  memory address; mem_rd_valid  in  1  read data valid; mem_rd_data  in  8  read data.
REQ-006 mem_wr_en  out  1  write strobe; mem_wr_data  out  8  write data.
REQ-007 alu_a  out  8  ALU operand a; alu_b  out  8  ALU operand b; alu_op  out  4  ALU opcode; alu_result  in  8  ALU result; alu_carry  in  1  ALU carry/borrow.
REQ-008 ac  out  8  accumulator; flag_n, flag_z, flag_c  out  1 each  negative, zero and carry flags.
REQ-009 done  out  1  one-cycle completion pulse; illegal  out  1  pulse with done for a reserved opcode; halted  out  1  sticky halt.

Function
REQ-010 instr_op encodings SHALL be: 0 NOP, 1 STA, 2 LDA, 3 ADD, 4 OR, 5 AND, 6 NOT, 7 SUB, 8 XOR, 9 SHL, A SHR, B NEG, F HLT, and C-E reserved.
REQ-011 alu_op SHALL encode ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, NOT=0101, SHL=0110, SHR=0111, NEG=1000.
REQ-012 The FSM SHALL have the states IDLE, RD_REQ, RD_WAIT, EXEC, WR, HALT.
REQ-013 instr_ready SHALL be 1 only in IDLE, and an instruction SHALL be accepted on the edge where instr_valid and instr_ready are both 1; instr_addr and instr_op SHALL be latched at that edge.
REQ-014 From IDLE on accept, the next state SHALL be: LDA/ADD/SUB/AND/OR/XOR to RD_REQ; NOT/SHL/SHR/NEG to EXEC; STA to WR; HLT to HALT; NOP or reserved to IDLE with done=1 on the next cycle (illegal=1 for reserved opcodes).
REQ-015 In RD_REQ, mem_rd_req SHALL be 1 for exactly one cycle with mem_addr equal to the latched address; the block SHALL then go to RD_WAIT, or go directly to EXEC if mem_rd_valid is 1 in RD_REQ.
REQ-016 In RD_WAIT the block SHALL hold until mem_rd_valid=1, capture mem_rd_data into an operand register, and go to EXEC; there is no timeout.
REQ-017 In EXEC, alu_a SHALL equal ac, alu_b SHALL equal the operand, and alu_op SHALL be set per the instruction; at the end of EXEC, ac SHALL be loaded with alu_result (LDA: with the operand directly) and the block SHALL go to IDLE.
REQ-018 Outside EXEC, alu_op SHALL be 0000, alu_a SHALL equal ac, and alu_b SHALL equal the operand register.
REQ-019 Whenever ac is written, N SHALL be set to new ac[7] and Z to (new ac==0).
REQ-020 C SHALL be set to alu_carry only for ADD/SUB/SHL/SHR/NEG; all other instructions SHALL leave C unchanged.
REQ-021 In WR, mem_wr_en SHALL be 1 for one cycle with mem_addr equal to the latched address and mem_wr_data equal to ac; flags SHALL be unchanged; the block SHALL then go to IDLE.
REQ-022 done SHALL be registered and asserted for exactly one cycle, in the first IDLE cycle after each instruction completes.
REQ-023 Latency from accept edge to done: NOP = 1 cycle; STA = 2; unary ops = 2; memory ops = 3 + read wait cycles (zero-wait memory = 3).
REQ-024 HALT SHALL be absorbing: halted=1, instr_ready=0, and no memory strobes until reset.
REQ-025 mem_rd_valid SHALL be ignored in IDLE, EXEC, WR and HALT.
REQ-026 In IDLE, mem_rd_req, mem_wr_en, done and illegal SHALL be 0 except for the done/illegal pulse defined in REQ-014 and REQ-022.

Reset
REQ-027 On reset, the block SHALL enter IDLE and set ac=00, N=0, Z=1, C=0, halted=0, done=0, illegal=0, mem_rd_req=0, mem_wr_en=0, and the operand and address registers to 00.
REQ-028 A reset asserted mid-instruction, including in RD_WAIT, SHALL abort the instruction with no done pulse and no memory write; a late mem_rd_valid after reset SHALL be ignored.
REQ-029 Reset SHALL take priority over all other events in the same cycle.

Structure
REQ-030 The instr_op encodings, alu_op encodings and FSM state enum SHALL reside in the shared package neander_x_pkg.
REQ-031 No sub-module SHALL be used: neander_alu SHALL be instantiated beside this block at CPU top level, and opcode-to-alu_op mapping SHALL be a combinational function in the package.

Verification
REQ-032 Scenario: LDA from addr 10 holding 80, zero-wait memory -> done 3 cycles after accept, ac=80, N=1, Z=0, C unchanged.
REQ-033 Scenario: ac=F0, ADD with operand 20 and read valid after 2 wait cycles -> ac=10, C=1, N=0, Z=0, done 5 cycles after accept.
REQ-034 Scenario: ac=01, SHR -> ac=00, C=1, Z=1; then NEG -> ac=00, C=0.
REQ-035 Scenario: ac=5A, STA to addr 33 -> one mem_wr_en cycle with addr 33 and data 5A, flags unchanged; opcode D -> done and illegal pulse together 1 cycle after accept.
REQ-036 Scenario: reset asserted in RD_WAIT, then mem_rd_valid arrives -> IDLE, ac=00, Z=1, no done pulse.
REQ-037 Scenario: HLT -> halted=1, instr_ready=0 for 20 cycles with instr_valid=1, no memory strobes; after reset, halted=0.
